// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: RES/NMI/IRQ arbitration and 6502 interrupt-entry microcycles.
// Optional INT_HIJACK_EN: a pending NMI takes over an IRQ entry during its push cycles.
module interrupt_sequencer #(
    parameter logic [7:0] VEC_PAGE = 8'hFF,
    parameter logic [7:0] VEC_NMI  = 8'hFA,
    parameter logic [7:0] VEC_RES  = 8'hFC,
    parameter logic [7:0] VEC_IRQ  = 8'hFE
) (
    input  logic        phi1,
    input  logic        rstAll,
    input  logic        RDY,
    input  logic        NMI_L,
    input  logic        IRQ_L,
    input  logic        RES_L,
    input  logic        flagI,
    input  logic        instBoundary,
    output logic        seqActive,
    output logic [2:0]  activeInt,
    output logic [2:0]  step,
    output logic        pushEn,
    output logic [1:0]  pushSel,
    output logic        pushB,
    output logic        spDec,
    output logic [15:0] vecAddr,
    output logic [1:0]  vecLoad,
    output logic        setI,
    output logic        intHandled
);

    localparam logic [2:0] INT_NONE = 3'd0;
    localparam logic [2:0] INT_RST  = 3'd1;
    localparam logic [2:0] INT_NMI  = 3'd2;
    localparam logic [2:0] INT_IRQ  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PUSH_PCH = 3'd1,
        S_PUSH_PCL = 3'd2,
        S_PUSH_P   = 3'd3,
        S_VEC_LO   = 3'd4,
        S_VEC_HI   = 3'd5,
        S_RES_HOLD = 3'd6
    } step_e;

    step_e      step_q, step_d;
    logic [2:0] act_q, act_d;
    logic       nmi_latch_q, nmi_latch_d;
    logic       nmi_prev_q, nmi_prev_d;
    logic       nmi_edge;
    logic       in_push;
    logic [7:0] vec_lo;

    always_ff @(posedge phi1) begin
        if (rstAll) begin
            step_q      <= S_IDLE;
            act_q       <= INT_NONE;
            nmi_latch_q <= 1'b0;
            nmi_prev_q  <= 1'b1;
        end else begin
            step_q      <= step_d;
            act_q       <= act_d;
            nmi_latch_q <= nmi_latch_d;
            nmi_prev_q  <= nmi_prev_d;
        end
    end

    always_comb begin
        step_d      = step_q;
        act_d       = act_q;
        nmi_prev_d  = NMI_L;
        nmi_edge    = nmi_prev_q & ~NMI_L;
        in_push     = (step_q == S_PUSH_PCH) || (step_q == S_PUSH_PCL)
                   || (step_q == S_PUSH_P);
        if (!RES_L) begin
            step_d = S_RES_HOLD;
            act_d  = INT_RST;
        end else begin
            case (step_q)
                S_IDLE: begin
                    if (instBoundary && RDY) begin
                        if (nmi_latch_q) begin
                            step_d = S_PUSH_PCH;
                            act_d  = INT_NMI;
                        end else if (!IRQ_L && !flagI) begin
                            step_d = S_PUSH_PCH;
                            act_d  = INT_IRQ;
                        end
                    end
                end
                S_PUSH_PCH: step_d = S_PUSH_PCL;
                S_PUSH_PCL: step_d = S_PUSH_P;
                S_PUSH_P:   step_d = S_VEC_LO;
                S_VEC_LO:   if (RDY) step_d = S_VEC_HI;
                S_VEC_HI: begin
                    if (RDY) begin
                        step_d = S_IDLE;
                        act_d  = INT_NONE;
                    end
                end
                S_RES_HOLD: step_d = S_PUSH_PCH;
                default: begin
                    step_d = S_IDLE;
                    act_d  = INT_NONE;
                end
            endcase
`ifdef INT_HIJACK_EN
            if (in_push && act_q == INT_IRQ && nmi_latch_q) act_d = INT_NMI;
`endif
        end
        // the latch is consumed on the vector fetch, but a fresh edge re-arms it
        nmi_latch_d = nmi_latch_q;
        if (step_d == S_VEC_LO && step_q != S_VEC_LO && act_d == INT_NMI)
            nmi_latch_d = 1'b0;
        if (nmi_edge) nmi_latch_d = 1'b1;
    end

    always_comb begin
        seqActive  = (step_q != S_IDLE);
        activeInt  = act_q;
        step       = step_q;
        pushEn     = 1'b0;
        pushSel    = 2'd0;
        pushB      = 1'b0;
        spDec      = 1'b0;
        vecAddr    = 16'd0;
        vecLoad    = 2'b00;
        setI       = 1'b0;
        intHandled = 1'b0;
        if (act_q == INT_NMI)      vec_lo = VEC_NMI;
        else if (act_q == INT_RST) vec_lo = VEC_RES;
        else                       vec_lo = VEC_IRQ;
        case (step_q)
            S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
                pushEn  = (act_q != INT_RST);
                pushSel = step_q[1:0] - 2'd1;
                spDec   = 1'b1;
            end
            S_VEC_LO: begin
                vecAddr = {VEC_PAGE, vec_lo};
                vecLoad = 2'b01;
                setI    = 1'b1;
            end
            S_VEC_HI: begin
                vecAddr    = {VEC_PAGE, vec_lo} + 16'd1;
                vecLoad    = 2'b10;
                intHandled = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed scenarios plus random traffic against
// a cycle-level reference model of the interrupt-entry rules.
module tb_interrupt_sequencer;

    logic        phi1 = 1'b0;
    logic        rstAll, RDY, NMI_L, IRQ_L, RES_L, flagI, instBoundary;
    logic        seqActive, pushEn, pushB, spDec, setI, intHandled;
    logic [2:0]  activeInt, step;
    logic [1:0]  pushSel, vecLoad;
    logic [15:0] vecAddr;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam int SRC_NONE = 0;
    localparam int SRC_RST  = 1;
    localparam int SRC_NMI  = 2;
    localparam int SRC_IRQ  = 3;

    int m_pos  = 0;
    int m_src  = SRC_NONE;
    bit m_pend = 1'b0;
    bit m_prev = 1'b1;

    always #5 phi1 = ~phi1;

    interrupt_sequencer dut (
        .phi1(phi1), .rstAll(rstAll), .RDY(RDY), .NMI_L(NMI_L),
        .IRQ_L(IRQ_L), .RES_L(RES_L), .flagI(flagI),
        .instBoundary(instBoundary), .seqActive(seqActive),
        .activeInt(activeInt), .step(step), .pushEn(pushEn),
        .pushSel(pushSel), .pushB(pushB), .spDec(spDec),
        .vecAddr(vecAddr), .vecLoad(vecLoad), .setI(setI),
        .intHandled(intHandled)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] src_code(input int s);
        case (s)
            SRC_RST: return 32'd1;
            SRC_NMI: return 32'd2;
            SRC_IRQ: return 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_outs();
        bit          push;
        logic [7:0]  lo;
        logic [15:0] va;
        logic [1:0]  vl;
        logic [1:0]  ps;
        push = (m_pos >= 1 && m_pos <= 3);
        lo   = (m_src == SRC_NMI) ? 8'hFA : (m_src == SRC_RST) ? 8'hFC : 8'hFE;
        va   = 16'd0;
        vl   = 2'd0;
        if (m_pos == 4) begin va = 16'hFF00 + 16'(lo);     vl = 2'd1; end
        if (m_pos == 5) begin va = 16'hFF00 + 16'(lo) + 1; vl = 2'd2; end
        ps = push ? 2'(m_pos - 1) : 2'd0;
        return {6'd0, 1'(m_pos != 0), 1'(push && m_src != SRC_RST), ps,
                1'b0, 1'(push), va, vl, 1'(m_pos == 4), 1'(m_pos == 5)};
    endfunction

    task automatic tick(input bit rst, input bit rdy, input bit nmi_l,
                        input bit irq_l, input bit res_l, input bit fi,
                        input bit ib);
        bit edge_s;
        int old;
        @(negedge phi1);
        rstAll = rst; RDY = rdy; NMI_L = nmi_l; IRQ_L = irq_l;
        RES_L = res_l; flagI = fi; instBoundary = ib;
        if (rst) begin
            m_pos = 0; m_src = SRC_NONE; m_pend = 1'b0; m_prev = 1'b1;
        end else begin
            edge_s = m_prev && !nmi_l;
            m_prev = nmi_l;
            old    = m_pos;
            if (!res_l) begin
                m_pos = 6; m_src = SRC_RST;
            end else if (m_pos == 0) begin
                if (ib && rdy) begin
                    if (m_pend) begin m_pos = 1; m_src = SRC_NMI; end
                    else if (!irq_l && !fi) begin m_pos = 1; m_src = SRC_IRQ; end
                end
            end else if (m_pos <= 3) begin
`ifdef INT_HIJACK_EN
                if (m_src == SRC_IRQ && m_pend) m_src = SRC_NMI;
`endif
                m_pos = m_pos + 1;
            end else if (m_pos == 4) begin
                if (rdy) m_pos = 5;
            end else if (m_pos == 5) begin
                if (rdy) begin m_pos = 0; m_src = SRC_NONE; end
            end else begin
                m_pos = 1;
            end
            if (m_pos == 4 && old != 4 && m_src == SRC_NMI) m_pend = 1'b0;
            if (edge_s) m_pend = 1'b1;
        end
        @(posedge phi1);
        #1;
        chk("step", 32'(step), 32'(m_pos));
        chk("activeInt", 32'(activeInt), src_code(m_src));
        chk("outs", {6'd0, seqActive, pushEn, pushSel, pushB, spDec,
                     vecAddr, vecLoad, setI, intHandled}, exp_outs());
    endtask

    initial begin
        bit r_nmi, r_irq, r_fi, r_rst, r_rdy, r_ib;
        int res_cnt;
        rstAll = 1'b1; RDY = 1'b1; NMI_L = 1'b1; IRQ_L = 1'b1;
        RES_L = 1'b1; flagI = 1'b0; instBoundary = 1'b0;

        // reset
        tick(1, 1, 1, 1, 1, 0, 0);
        tick(1, 1, 1, 1, 1, 0, 0);
        chk("rst_idle", {seqActive, activeInt, vecAddr, vecLoad}, 32'd0);

        // plain IRQ entry
        tick(0, 1, 1, 0, 1, 0, 1);
        chk("t1_s1", 32'(step), 32'd1);
        tick(0, 1, 1, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 1, 0, 0);
        chk("t1_vlo", 32'(vecAddr), 32'hFFFE);
        tick(0, 1, 1, 1, 1, 0, 0);
        chk("t1_vhi", {vecAddr, 7'd0, intHandled}, {16'hFFFF, 8'd1} );
        tick(0, 1, 1, 1, 1, 0, 0);

        // RDY stall in VEC_LO, then reset mid-push
        tick(0, 1, 1, 0, 1, 0, 1);
        tick(0, 1, 1, 0, 1, 0, 0);
        tick(0, 1, 1, 0, 1, 0, 0);
        tick(0, 1, 1, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 1, 0, 0);
        chk("t6_hold", {vecAddr, vecLoad}, {16'hFFFE, 2'b01});
        tick(0, 1, 1, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 1, 0, 0);
        tick(0, 1, 1, 0, 1, 0, 1);
        tick(0, 1, 1, 0, 1, 0, 0);
        tick(0, 1, 1, 0, 1, 0, 0);
        tick(1, 1, 1, 0, 1, 0, 0);
        chk("t6_rst", {seqActive, pushEn, spDec, 1'b0, activeInt}, 32'd0);

        // masked IRQ, then one NMI from a held-low pin
        tick(0, 1, 1, 0, 1, 1, 1);
        chk("t2_mask", 32'(seqActive), 32'd0);
        tick(0, 1, 0, 1, 1, 0, 0);
        tick(0, 1, 0, 1, 1, 0, 1);
        tick(0, 1, 0, 1, 1, 0, 0);
        tick(0, 1, 0, 1, 1, 0, 0);
        tick(0, 1, 0, 1, 1, 0, 0);
        chk("t2_vec", 32'(vecAddr), 32'hFFFA);
        tick(0, 1, 0, 1, 1, 0, 0);
        tick(0, 1, 0, 1, 1, 0, 0);
        tick(0, 1, 0, 1, 1, 0, 1);
        chk("t2_once", 32'(seqActive), 32'd0);
        tick(0, 1, 1, 1, 1, 0, 0);

        // RES during IRQ push, dummy-push reset entry
        tick(0, 1, 1, 0, 1, 0, 1);
        tick(0, 1, 1, 0, 1, 0, 0);
        tick(0, 1, 1, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0, 0, 0);
        chk("t3_hold", {step, pushEn}, {3'd6, 1'b0});
        tick(0, 1, 1, 1, 1, 0, 0);
        chk("t3_dummy", {pushEn, spDec}, 2'b01);
        tick(0, 1, 1, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 1, 0, 0);
        chk("t3_vec", 32'(vecAddr), 32'hFFFC);
        tick(0, 1, 1, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 1, 0, 0);

        // NMI edge during IRQ push
        tick(0, 1, 1, 0, 1, 0, 1);
        tick(0, 1, 0, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 1, 0, 0);
`ifdef INT_HIJACK_EN
        chk("t5_vec", 32'(vecAddr), 32'hFFFA);
`else
        chk("t5_vec", 32'(vecAddr), 32'hFFFE);
`endif
        tick(0, 1, 0, 1, 1, 0, 0);
        tick(0, 1, 0, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 1, 0, 1);
        for (int i = 0; i < 5; i++) tick(0, 1, 1, 1, 1, 0, 0);

        // random traffic
        r_nmi = 1'b1;
        res_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r_nmi = ~r_nmi;
            if (res_cnt > 0) res_cnt--;
            else if ($urandom_range(0, 59) == 0) res_cnt = $urandom_range(1, 4);
            r_irq = ($urandom_range(0, 1) == 0);
            r_fi  = ($urandom_range(0, 3) == 0);
            r_rst = ($urandom_range(0, 99) == 0);
            r_rdy = ($urandom_range(0, 4) != 0);
            r_ib  = ($urandom_range(0, 2) == 0);
            tick(r_rst, r_rdy, r_nmi, r_irq, (res_cnt == 0), r_fi, r_ib);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
